// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with per-requester burst quotas, a runtime
// fixed-priority mode and a registered one-hot grant.
module weighted_rr_arbiter #(
  parameter int unsigned ARBITER_WIDTH = 8,
  parameter int unsigned WEIGHT_W      = 4,
  parameter int unsigned IDX_W         = $clog2(ARBITER_WIDTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ARBITER_WIDTH-1:0]          request,
  input  logic [ARBITER_WIDTH*WEIGHT_W-1:0] weight,
  input  logic                              fixed_mode,
  output logic [ARBITER_WIDTH-1:0]          grant,
  output logic                              any_grant,
  output logic [IDX_W-1:0]                  grant_idx
);

  localparam int unsigned CNT_W = WEIGHT_W + 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  // grant_idx doubles as the owner register and any_grant as its valid bit.
  logic [IDX_W-1:0]    last_idx;
  logic [CNT_W-1:0]    burst_cnt;
  logic [WEIGHT_W-1:0] owner_wt;
  logic [CNT_W-1:0]    eff_wt;
  logic                owner_req;
  logic                hold;
  logic [IDX_W-1:0]    rr_win;
  logic [IDX_W-1:0]    fp_win;
  logic [IDX_W-1:0]    win;
  logic                rr_found;
  logic [PTR_W-1:0]    cand;

  // Live quota and request of the current owner; decide whether the burst continues.
  always_comb begin
    owner_wt  = '0;
    owner_req = 1'b0;
    for (int i = 0; i < int'(ARBITER_WIDTH); i++) begin
      if (grant_idx == IDX_W'(i)) begin
        owner_wt  = weight[i*WEIGHT_W +: WEIGHT_W];
        owner_req = request[i];
      end
    end
    eff_wt = (owner_wt == '0) ? CNT_W'(1) : {1'b0, owner_wt};
    hold   = any_grant && owner_req && (burst_cnt < eff_wt);
  end

  // Winner search: rotating from last_idx+1, or lowest index in fixed mode.
  always_comb begin
    fp_win   = '0;
    rr_win   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = int'(ARBITER_WIDTH) - 1; i >= 0; i--) begin
      if (request[i]) fp_win = IDX_W'(i);
    end
    for (int off = 1; off <= int'(ARBITER_WIDTH); off++) begin
      cand = {1'b0, last_idx} + PTR_W'(off);
      if (cand >= PTR_W'(ARBITER_WIDTH)) cand = cand - PTR_W'(ARBITER_WIDTH);
      if (!rr_found && request[cand[IDX_W-1:0]]) begin
        rr_win   = cand[IDX_W-1:0];
        rr_found = 1'b1;
      end
    end
    win = fixed_mode ? fp_win : rr_win;
  end

  // Hold / arbitrate / idle update of the owner, burst counter and pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      any_grant <= 1'b0;
      grant_idx <= '0;
      burst_cnt <= '0;
      last_idx  <= IDX_W'(ARBITER_WIDTH - 1);
    end else if (hold) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end else if (|request) begin
      grant     <= ARBITER_WIDTH'(1) << win;
      any_grant <= 1'b1;
      grant_idx <= win;
      burst_cnt <= CNT_W'(1);
      last_idx  <= win;
    end else begin
      grant     <= '0;
      any_grant <= 1'b0;
      burst_cnt <= '0;
    end
  end

endmodule
